// File: rtl/div_tick_counter.sv
// div_tick_counter: counts rising edges of a selected divided clock under IDLE/RUN/HOLD control
// clk_in, rst (async, active-low); clk_div_2/4/8/16 divider levels; sel picks the source;
// start/stop/clear level requests; tick = registered edge pulse; count = ticks seen in RUN;
// running = state is RUN; wrap = one-cycle pulse when count rolls over to zero.
module div_tick_counter #(
  parameter int CNT_W = 8
) (
  input  logic             clk_in,
  input  logic             rst,
  input  logic             clk_div_2,
  input  logic             clk_div_4,
  input  logic             clk_div_8,
  input  logic             clk_div_16,
  input  logic [1:0]       sel,
  input  logic             start,
  input  logic             stop,
  input  logic             clear,
  output logic             tick,
  output logic [CNT_W-1:0] count,
  output logic             running,
  output logic             wrap
);
  typedef enum logic [1:0] {IDLE = 2'd0, RUN = 2'd1, HOLD = 2'd2} state_t;
  state_t     state, state_nx;
  logic [3:0] src, prev;
  logic       rise, cnt_en;
  assign src     = {clk_div_16, clk_div_8, clk_div_4, clk_div_2};
  // every prev tracks its own input, so switching sel never fakes an edge
  assign rise    = src[sel] & ~prev[sel];
  // gated by the registered state: an edge sampled with stop still counts, one with clear does not
  assign cnt_en  = (state == RUN) & rise & ~clear;
  assign running = (state == RUN);
  always_comb begin
    state_nx = state;
    if (clear)
      state_nx = IDLE;
    else if (stop)
      state_nx = (state == RUN) ? HOLD : state;
    else if (start)
      state_nx = RUN;
  end
  // prev resets to 1 so a source already high at reset release is not seen as rising
  always_ff @(posedge clk_in or negedge rst) begin
    if (!rst) begin
      state <= IDLE;
      prev  <= 4'hF;
      tick  <= 1'b0;
      wrap  <= 1'b0;
      count <= '0;
    end else begin
      state <= state_nx;
      prev  <= src;
      tick  <= rise;
      wrap  <= cnt_en & (&count);
      count <= clear ? '0 : cnt_en ? count + CNT_W'(1) : count;
    end
  end
endmodule
